// File: rtl/io_checkpoint_seq.sv
// io_checkpoint_seq
//   Watches a data/tag bus for a programmed sequence of checkpoint values.
//   Each step in the table must be seen for STABLE_CYC consecutive cycles
//   before the next step is awaited. If a step is not accepted before its
//   timeout counter saturates, the sequence fails.
//
// Ports
//   wb_clk_i    clock, rising edge
//   wb_rst_i    asynchronous active-high reset
//   start_i     pulse that arms the sequence (ignored while running)
//   nsteps_i    number of active steps, sampled on an accepted start
//   data_i      monitored checkpoint data
//   tag_i       monitored qualifier tag
//   cfg_we_i    table write strobe (dropped while running)
//   cfg_idx_i   table entry index
//   cfg_data_i  expected data for the entry
//   cfg_mask_i  compare mask for the entry (1 = bit is compared)
//   cfg_tag_i   expected tag for the entry
//   busy_o      sequence running
//   pass_o      sticky pass flag
//   fail_o      sticky fail flag
//   step_o      step currently awaited, or the step that failed
//   timeout_o   the failure was caused by a step timeout
module io_checkpoint_seq #(
    parameter int DATA_W     = 16,
    parameter int TAG_W      = 2,
    parameter int NUM_STEPS  = 4,
    parameter int TIMEOUT_W  = 20,
    parameter int STABLE_CYC = 2,
    localparam int IDX_W     = $clog2(NUM_STEPS),
    localparam int NS_W      = IDX_W + 1,
    localparam int STAB_W    = $clog2(STABLE_CYC + 1)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [NS_W-1:0]   nsteps_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic [DATA_W-1:0] cfg_mask_i,
    input  logic [TAG_W-1:0]  cfg_tag_i,
    output logic              busy_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [IDX_W-1:0]  step_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     step_q, step_d;
    logic [NS_W-1:0]      nsteps_q, nsteps_d;
    logic [STAB_W-1:0]    stab_q, stab_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_flag_q, tmo_flag_d;

    logic [DATA_W-1:0]    exp_data_q [NUM_STEPS];
    logic [DATA_W-1:0]    exp_data_d [NUM_STEPS];
    logic [DATA_W-1:0]    exp_mask_q [NUM_STEPS];
    logic [DATA_W-1:0]    exp_mask_d [NUM_STEPS];
    logic [TAG_W-1:0]     exp_tag_q  [NUM_STEPS];
    logic [TAG_W-1:0]     exp_tag_d  [NUM_STEPS];

    logic                 match;
    logic                 last_step;
    logic                 nsteps_bad;
    logic [STAB_W-1:0]    stab_inc;
    logic [TIMEOUT_W-1:0] tmo_inc;

    // Compare the bus against the entry for the step currently awaited.
    // Only bits set in the mask take part in the data comparison.
    always_comb begin
        match      = (((data_i ^ exp_data_q[step_q]) & exp_mask_q[step_q]) == '0)
                     && (tag_i == exp_tag_q[step_q]);
        last_step  = ({1'b0, step_q} == (nsteps_q - NS_W'(1)));
        nsteps_bad = (nsteps_i == '0) || (nsteps_i > NS_W'(NUM_STEPS));
        stab_inc   = stab_q + STAB_W'(1);
        tmo_inc    = tmo_cnt_q + TIMEOUT_W'(1);
    end

    // Next-state logic. Acceptance is evaluated before the timeout so that
    // a step accepted on the saturating cycle still advances. On the final
    // step the index is held so step_o reports the last accepted step.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        nsteps_d   = nsteps_q;
        stab_d     = stab_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_flag_d = tmo_flag_q;
        exp_data_d = exp_data_q;
        exp_mask_d = exp_mask_q;
        exp_tag_d  = exp_tag_q;

        case (state_q)
            RUN: begin
                if (match && (stab_inc == STAB_W'(STABLE_CYC))) begin
                    stab_d    = '0;
                    tmo_cnt_d = '0;
                    if (last_step) begin
                        state_d = PASS;
                    end else begin
                        step_d = step_q + IDX_W'(1);
                    end
                end else begin
                    stab_d    = match ? stab_inc : '0;
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == '1) begin
                        state_d    = FAIL;
                        tmo_flag_d = 1'b1;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    step_d     = '0;
                    stab_d     = '0;
                    tmo_cnt_d  = '0;
                    tmo_flag_d = 1'b0;
                    nsteps_d   = nsteps_i;
                    state_d    = nsteps_bad ? FAIL : RUN;
                end
                if (cfg_we_i && ({1'b0, cfg_idx_i} < NS_W'(NUM_STEPS))) begin
                    exp_data_d[cfg_idx_i] = cfg_data_i;
                    exp_mask_d[cfg_idx_i] = cfg_mask_i;
                    exp_tag_d[cfg_idx_i]  = cfg_tag_i;
                end
            end
        endcase
    end

    // State, counters and table; reset clears everything including the table.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            step_q     <= '0;
            nsteps_q   <= '0;
            stab_q     <= '0;
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                exp_data_q[i] <= '0;
                exp_mask_q[i] <= '0;
                exp_tag_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            nsteps_q   <= nsteps_d;
            stab_q     <= stab_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
            exp_data_q <= exp_data_d;
            exp_mask_q <= exp_mask_d;
            exp_tag_q  <= exp_tag_d;
        end
    end

    assign busy_o    = (state_q == RUN);
    assign pass_o    = (state_q == PASS);
    assign fail_o    = (state_q == FAIL);
    assign step_o    = step_q;
    assign timeout_o = tmo_flag_q;

endmodule

// File: tb/tb_io_checkpoint_seq.sv
// Testbench for io_checkpoint_seq with a 4-bit timeout counter so that a
// step times out after 15 running cycles. Final results of each sequence
// are queued when the sequence is started and compared when busy_o drops.
module tb_io_checkpoint_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  nsteps_i;
    logic [15:0] data_i;
    logic [1:0]  tag_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_idx_i;
    logic [15:0] cfg_data_i;
    logic [15:0] cfg_mask_i;
    logic [1:0]  cfg_tag_i;
    logic        busy_o;
    logic        pass_o;
    logic        fail_o;
    logic [1:0]  step_o;
    logic        timeout_o;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic       pass;
        logic       fail;
        logic       tmo;
        logic [1:0] step;
    } exp_t;

    exp_t sb[$];

    io_checkpoint_seq #(
        .DATA_W(16), .TAG_W(2), .NUM_STEPS(4), .TIMEOUT_W(4), .STABLE_CYC(2)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .start_i(start_i),
        .nsteps_i(nsteps_i),
        .data_i(data_i),
        .tag_i(tag_i),
        .cfg_we_i(cfg_we_i),
        .cfg_idx_i(cfg_idx_i),
        .cfg_data_i(cfg_data_i),
        .cfg_mask_i(cfg_mask_i),
        .cfg_tag_i(cfg_tag_i),
        .busy_o(busy_o),
        .pass_o(pass_o),
        .fail_o(fail_o),
        .step_o(step_o),
        .timeout_o(timeout_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [1:0] t, input int n);
        data_i = d;
        tag_i  = t;
        tick(n);
    endtask

    task automatic writeEntry(input logic [1:0] idx, input logic [15:0] d,
                              input logic [15:0] m, input logic [1:0] t);
        cfg_idx_i  = idx;
        cfg_data_i = d;
        cfg_mask_i = m;
        cfg_tag_i  = t;
        cfg_we_i   = 1'b1;
        tick(1);
        cfg_we_i   = 1'b0;
    endtask

    task automatic startSeq(input logic [2:0] n);
        nsteps_i = n;
        start_i  = 1'b1;
        tick(1);
        start_i  = 1'b0;
    endtask

    task automatic pushExpect(input logic p, input logic f, input logic t, input logic [1:0] s);
        exp_t e;
        e.pass = p;
        e.fail = f;
        e.tmo  = t;
        e.step = s;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the sequence to finish, then compare against the
    // oldest queued expectation.
    task automatic waitDone(input string tag, input int bound);
        int   n;
        exp_t e;
        n = 0;
        while (busy_o && n < bound) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_done"}, {31'd0, busy_o}, 32'd0);
        if (sb.size() == 0) begin
            assert_count++;
            fail_count++;
            $error("[TB] FAIL %s_queue: observed empty scoreboard, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_pass"},    {31'd0, pass_o},    {31'd0, e.pass});
            checkOutput({tag, "_fail"},    {31'd0, fail_o},    {31'd0, e.fail});
            checkOutput({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, e.tmo});
            checkOutput({tag, "_step"},    {30'd0, step_o},    {30'd0, e.step});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        nsteps_i   = 3'd0;
        data_i     = 16'h0000;
        tag_i      = 2'd0;
        cfg_we_i   = 1'b0;
        cfg_idx_i  = 2'd0;
        cfg_data_i = 16'h0000;
        cfg_mask_i = 16'h0000;
        cfg_tag_i  = 2'd0;
        tick(2);
        checkOutput("rst_busy",    {31'd0, busy_o},    32'd0);
        checkOutput("rst_pass",    {31'd0, pass_o},    32'd0);
        checkOutput("rst_fail",    {31'd0, fail_o},    32'd0);
        checkOutput("rst_timeout", {31'd0, timeout_o}, 32'd0);
        checkOutput("rst_step",    {30'd0, step_o},    32'd0);
        rst = 1'b0;
        tick(1);

        // Two-step pass: 0x00FF for two cycles, then 0x0001 for two cycles.
        $display("[TB] two-step pass sequence");
        writeEntry(2'd0, 16'h00FF, 16'hFFFF, 2'd0);
        writeEntry(2'd1, 16'h0001, 16'hFFFF, 2'd0);
        data_i = 16'h00FF;
        tag_i  = 2'd0;
        startSeq(3'd2);
        pushExpect(1'b1, 1'b0, 1'b0, 2'd1);
        checkOutput("p34_busy_start", {31'd0, busy_o}, 32'd1);
        applyStimulus(16'h00FF, 2'd0, 2);
        checkOutput("p34_step_adv", {30'd0, step_o}, 32'd1);
        applyStimulus(16'h0001, 2'd0, 1);
        checkOutput("p34_busy_mid", {31'd0, busy_o}, 32'd1);
        applyStimulus(16'h0001, 2'd0, 1);
        checkOutput("p34_busy_end", {31'd0, busy_o}, 32'd0);
        waitDone("p34", 4);

        // An interrupted match must restart the stability count.
        $display("[TB] stability interruption then step-1 timeout");
        data_i = 16'h00FF;
        startSeq(3'd2);
        pushExpect(1'b0, 1'b1, 1'b1, 2'd1);
        applyStimulus(16'h00FF, 2'd0, 1);
        applyStimulus(16'h1234, 2'd0, 1);
        checkOutput("p35_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("p35_step", {30'd0, step_o}, 32'd0);
        applyStimulus(16'h00FF, 2'd0, 1);
        checkOutput("p35_not_yet", {30'd0, step_o}, 32'd0);
        applyStimulus(16'h00FF, 2'd0, 1);
        checkOutput("p35_accept", {30'd0, step_o}, 32'd1);
        applyStimulus(16'h1234, 2'd0, 14);
        checkOutput("p35_busy_14", {31'd0, busy_o}, 32'd1);
        tick(1);
        checkOutput("p35_busy_15", {31'd0, busy_o}, 32'd0);
        waitDone("p35", 4);

        // Data never matches step 0: timeout after exactly 15 running cycles.
        $display("[TB] step-0 timeout");
        data_i = 16'h1234;
        startSeq(3'd2);
        pushExpect(1'b0, 1'b1, 1'b1, 2'd0);
        tick(14);
        checkOutput("p36_busy_14", {31'd0, busy_o}, 32'd1);
        tick(1);
        checkOutput("p36_busy_15", {31'd0, busy_o}, 32'd0);
        waitDone("p36", 4);

        // Masked compare with matching tag.
        $display("[TB] masked compare");
        writeEntry(2'd0, 16'h0050, 16'h00F0, 2'd1);
        data_i = 16'hAB5C;
        tag_i  = 2'd1;
        startSeq(3'd1);
        pushExpect(1'b1, 1'b0, 1'b0, 2'd0);
        tick(1);
        checkOutput("p37_busy", {31'd0, busy_o}, 32'd1);
        tick(1);
        checkOutput("p37_pass_now", {31'd0, pass_o}, 32'd1);
        waitDone("p37", 4);

        // Tag mismatch, plus start and table write while running are ignored.
        $display("[TB] tag mismatch with ignored start and table write");
        tag_i = 2'd2;
        startSeq(3'd1);
        pushExpect(1'b0, 1'b1, 1'b1, 2'd0);
        tick(3);
        checkOutput("p37_tag_busy", {31'd0, busy_o}, 32'd1);
        start_i    = 1'b1;
        nsteps_i   = 3'd1;
        cfg_we_i   = 1'b1;
        cfg_idx_i  = 2'd0;
        cfg_data_i = 16'hAB5C;
        cfg_mask_i = 16'hFFFF;
        cfg_tag_i  = 2'd2;
        tick(1);
        start_i  = 1'b0;
        cfg_we_i = 1'b0;
        tick(10);
        checkOutput("p38_busy_14", {31'd0, busy_o}, 32'd1);
        tick(1);
        checkOutput("p38_busy_15", {31'd0, busy_o}, 32'd0);
        waitDone("p38_run", 4);

        // Invalid step counts fail immediately without timeout.
        $display("[TB] invalid step counts");
        startSeq(3'd0);
        pushExpect(1'b0, 1'b1, 1'b0, 2'd0);
        waitDone("p38_zero", 2);
        startSeq(3'd5);
        pushExpect(1'b0, 1'b1, 1'b0, 2'd0);
        waitDone("p38_five", 2);

        // Reset in the middle of a run, then restart on the cleared table.
        $display("[TB] reset mid-run");
        writeEntry(2'd0, 16'h00FF, 16'hFFFF, 2'd0);
        writeEntry(2'd1, 16'h0001, 16'hFFFF, 2'd0);
        data_i = 16'h00FF;
        tag_i  = 2'd0;
        startSeq(3'd2);
        tick(2);
        checkOutput("p39_pre_step", {30'd0, step_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("p39_busy",    {31'd0, busy_o},    32'd0);
        checkOutput("p39_pass",    {31'd0, pass_o},    32'd0);
        checkOutput("p39_fail",    {31'd0, fail_o},    32'd0);
        checkOutput("p39_timeout", {31'd0, timeout_o}, 32'd0);
        checkOutput("p39_step",    {30'd0, step_o},    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        data_i = 16'h1234;
        startSeq(3'd1);
        pushExpect(1'b1, 1'b0, 1'b0, 2'd0);
        checkOutput("p39_restart_busy", {31'd0, busy_o}, 32'd1);
        checkOutput("p39_restart_step", {30'd0, step_o}, 32'd0);
        tick(2);
        checkOutput("p39_cleared_pass", {31'd0, pass_o}, 32'd1);
        waitDone("p39", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
